// File: rtl/sys_ctrl_host.sv
// Host end of the sys_ctrl command link: serialises a command over a UART
// transmitter, then collects the one-byte reply (or times out) and reports it.
module sys_ctrl_host #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        resp_err,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [3:0]  state_out
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        TX_LOAD    = 4'd1,
        TX_WAIT_HI = 4'd2,
        TX_WAIT_LO = 4'd3,
        RX_WAIT    = 4'd4,
        RESP       = 4'd5
    } state_t;

    state_t      state;
    logic [7:0]  op_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [2:0]  byte_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] to_cnt;
    logic [7:0]  rx_byte;
    logic        rx_got;

    logic [7:0]  cur_byte;
    logic [2:0]  req_cnt;
    logic        last_byte;
    logic [7:0]  early_byte;

    always_comb begin
        cur_byte = op_q;
        case (byte_idx)
            2'd1:    cur_byte = addr_q[15:8];
            2'd2:    cur_byte = addr_q[7:0];
            2'd3:    cur_byte = data_q;
            default: cur_byte = op_q;
        endcase
        case (req_op)
            8'h02:   req_cnt = 3'd4;
            8'h03:   req_cnt = 3'd3;
            default: req_cnt = 3'd1;
        endcase
        last_byte  = ({1'b0, byte_idx} + 3'd1) == byte_cnt;
        // A reply can land in the same cycle the last byte finishes.
        early_byte = rx_valid ? rx_data : rx_byte;
    end

    assign state_out = state;

    function automatic logic err_of(input logic [7:0] op, input logic [7:0] b);
        return (op == 8'h03) ? 1'b0 : (b != 8'h00);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
            resp_err   <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            op_q       <= 8'h00;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            byte_cnt   <= 3'd0;
            byte_idx   <= 2'd0;
            to_cnt     <= 24'd0;
            rx_byte    <= 8'h00;
            rx_got     <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    rx_got <= 1'b0;
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        data_q    <= req_data;
                        byte_idx  <= 2'd0;
                        to_cnt    <= 24'd0;
                        req_ready <= 1'b0;
                        if (req_op > 8'h05) begin
                            byte_cnt   <= 3'd0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 8'h00;
                            state      <= RESP;
                        end else begin
                            byte_cnt <= req_cnt;
                            state    <= TX_LOAD;
                        end
                    end
                end
                TX_LOAD: begin
                    if (!tx_active) begin
                        tx_data  <= cur_byte;
                        tx_start <= 1'b1;
                        state    <= TX_WAIT_HI;
                    end
                end
                TX_WAIT_HI: begin
                    if (last_byte && rx_valid) begin
                        rx_byte <= rx_data;
                        rx_got  <= 1'b1;
                    end
                    if (tx_active) state <= TX_WAIT_LO;
                end
                TX_WAIT_LO: begin
                    if (last_byte && rx_valid) begin
                        rx_byte <= rx_data;
                        rx_got  <= 1'b1;
                    end
                    if (!tx_active) begin
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= TX_LOAD;
                        end else if (rx_valid || rx_got) begin
                            resp_valid <= 1'b1;
                            resp_data  <= early_byte;
                            resp_err   <= err_of(op_q, early_byte);
                            state      <= RESP;
                        end else begin
                            to_cnt <= 24'd0;
                            state  <= RX_WAIT;
                        end
                    end
                end
                RX_WAIT: begin
                    if (rx_valid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= rx_data;
                        resp_err   <= err_of(op_q, rx_data);
                        state      <= RESP;
                    end else begin
                        if (to_cnt != TIMEOUT) to_cnt <= to_cnt + 24'd1;
                        if (to_cnt == TIMEOUT || (to_cnt + 24'd1) == TIMEOUT) begin
                            resp_valid <= 1'b1;
                            resp_data  <= 8'h00;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_data  <= 8'h00;
                    resp_err   <= 1'b0;
                    tx_start   <= 1'b0;
                    tx_data    <= 8'h00;
                    op_q       <= 8'h00;
                    addr_q     <= 16'h0000;
                    data_q     <= 8'h00;
                    byte_cnt   <= 3'd0;
                    byte_idx   <= 2'd0;
                    to_cnt     <= 24'd0;
                    rx_byte    <= 8'h00;
                    rx_got     <= 1'b0;
                end
            endcase
        end
    end

endmodule
